modred_shiftadd_param: RTL

MODRED_SHIFTADD_PARAM -- requirements
Module: modred_shiftadd_param

---
 rtl/modred_shiftadd_param.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/modred_shiftadd_param.sv
// Purpose : computes x mod m by restoring shift-subtract, SPC steps per clock.
// Latency : 1 cycle to DONE for fast-path/illegal requests, else ceil((X_W-m_bl+1)/SPC) REDUCE cycles then DONE.
// Backpressure: accepts only in IDLE; DONE holds the result until out_ready_i, so at most one request is in flight.
module modred_shiftadd_param #(
    parameter int DATA_W = 64,
    parameter int X_W    = 2 * DATA_W,
    parameter int SPC    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [X_W-1:0]               x_i,
    input  logic [DATA_W-1:0]            m_i,
    input  logic [$clog2(DATA_W+1)-1:0]  m_bl_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            result_o,
    output logic                         err_o,
    output logic                         busy_o
);

    localparam int BL_W = $clog2(DATA_W + 1);
    // k runs from X_W - m_bl (at most X_W - 1) down to 0.
    localparam int K_W  = $clog2(X_W + 1);
    // Width at which m << k is formed so the shift never loses bits.
    localparam int WW   = X_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [X_W-1:0]     r_q;
    logic [DATA_W-1:0]  m_q;
    logic [K_W-1:0]     k_q;
    logic [DATA_W-1:0]  result_q;
    logic               err_q;

    // Request decode (only meaningful in IDLE).
    logic               msb_set;
    logic               req_illegal;
    logic               req_fast;
    logic [K_W-1:0]     k_init;

    // One clock's worth of chained reduction steps.
    logic [X_W-1:0]     r_step;
    logic [K_W-1:0]     k_step;
    logic               red_last;

    // Classify the incoming request: legality, fast path and starting shift.
    always_comb begin
        msb_set = 1'b0;
        // m_bl is legal only if it points at a set bit of m; out-of-range m_bl leaves msb_set low.
        for (int i = 0; i < DATA_W; i++) begin
            if (m_bl_i == BL_W'(i + 1)) begin
                msb_set = m_i[i];
            end
        end
        req_illegal = (m_i == '0) || (m_bl_i == '0) ||
                      (m_bl_i > BL_W'(DATA_W)) || !msb_set;
        req_fast    = (x_i < X_W'(m_i));
        k_init      = K_W'(X_W) - K_W'(m_bl_i);
    end

    // Chain up to SPC restoring steps; stop early once the k == 0 step has run.
    always_comb begin
        logic [WW-1:0]  c;
        logic [X_W-1:0] r_t;
        logic [K_W-1:0] k_t;
        logic           last;
        c    = '0;
        r_t  = r_q;
        k_t  = k_q;
        last = 1'b0;
        for (int s = 0; s < SPC; s++) begin
            if (!last) begin
                c = WW'(m_q) << k_t;
                // r fits in X_W bits, so any set bit of c above X_W means c > r;
                // this is the full-width r >= c test without widening r.
                if ((c[WW-1:X_W] == '0) && (r_t >= c[X_W-1:0])) begin
                    r_t = r_t - c[X_W-1:0];
                end
                if (k_t == '0) begin
                    last = 1'b1;
                end else begin
                    k_t = k_t - K_W'(1);
                end
            end
        end
        r_step   = r_t;
        k_step   = k_t;
        red_last = last;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) begin
                    state_d = (req_illegal || req_fast) ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                if (red_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                // Returning to IDLE here means the next accept is one edge later.
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Working remainder, modulus, step counter and registered result/error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q      <= '0;
            m_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        r_q <= x_i;
                        m_q <= m_i;
                        k_q <= k_init;
                        if (req_illegal) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                        end else if (req_fast) begin
                            result_q <= x_i[DATA_W-1:0];
                            err_q    <= 1'b0;
                        end
                    end
                end
                REDUCE: begin
                    r_q <= r_step;
                    k_q <= k_step;
                    if (red_last) begin
                        result_q <= r_step[DATA_W-1:0];
                        err_q    <= 1'b0;
                    end
                end
                default: begin
                    // DONE holds everything until the consumer takes it.
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign err_o    = err_q;

endmodule
